key_event_gen: RTL and testbench
================================

# key_event_gen

Converts the debounced, active-low key levels produced by the per-key debounce filters into discrete, single-cycle key events for the vending controller. Tracks one key at a time and classifies each press as short, long, or (optionally) auto-repeat. Sits directly downstream of the debounce stage and upstream of the seller control FSM.

## Interface
- NUM_KEYS, 4, number of debounced key inputs
- LONG_TIME, 50_000_000, hold cycles before a LONG event (1 s at 50 MHz)
- REPEAT_TIME, 10_000_000, cycles between REPEAT events after LONG (200 ms)
- CODE_W, 2, width of event_code; must hold NUM_KEYS-1
---
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- key_in  in  NUM_KEYS  debounced key levels, 0 = pressed; already synchronous to clk, no resync
- event_valid  out  1  one-cycle event strobe
- event_type  out  2  01 SHORT, 10 LONG, 11 REPEAT; 00 never emitted with event_valid
- event_code  out  CODE_W  index of key that produced the event
- key_busy  out  1  high whenever FSM is not IDLE

## Operation
- States: IDLE, HELD, LONG, WAIT_REL. 32-bit hold counter `cnt`.
- IDLE: if any key_in bit is 0, latch lowest-index low bit as tracked key, cnt <= 0, go HELD. No event on press.
- HELD: tracked key high -> emit SHORT, go WAIT_REL. Else if cnt == LONG_TIME-1 -> emit LONG, cnt <= 0, go LONG. Else cnt++.
- LONG: tracked key high -> go WAIT_REL, no event. Else (KEY_REPEAT_EN) cnt == REPEAT_TIME-1 -> emit REPEAT, cnt <= 0; else cnt++.
- WAIT_REL: stay until key_in is all ones, then IDLE. Blocks new tracking while any key held.
- Other keys pressed while tracking are ignored; never produce events until full release and a fresh press.
- Release has priority: release sampled on the edge where cnt would reach terminal -> SHORT (or nothing in LONG), no LONG/REPEAT.
- event_code holds last latched key index between events; event_type holds last type.

## Timing
- Reset: event_valid 0, event_type 00, event_code 0, key_busy 0, state IDLE, cnt 0.
- All outputs registered. Press sampled at edge E0 -> key_busy high after E0.
- LONG event_valid high for the single cycle after edge E0+LONG_TIME (key held continuously).
- REPEAT pulses at E0+LONG_TIME+k*REPEAT_TIME, k = 1,2,...
- SHORT: release sampled at edge Er -> event_valid high for cycle after Er; key_busy falls after Er+1 at earliest (WAIT_REL sees all-ones).
- Reset mid-operation: outputs clear immediately, no pending event emitted; if a key is still low after reset release, IDLE treats it as a new press.
- Minimum event spacing 2 cycles; consumer needs no handshake.

## Configuration
- KEY_REPEAT_EN defined: REPEAT events generated in LONG as above.
- Undefined: LONG state only waits for release; no REPEAT events; REPEAT_TIME unused; event_type 11 never produced.

## Test plan
Params: NUM_KEYS=4, LONG_TIME=10, REPEAT_TIME=4.
- Reset with key_in=4'b1111, hold 5 cycles -> all outputs 0, key_busy 0.
- key_in=4'b1011 for 5 cycles then 4'b1111 -> one pulse, type 01, code 2, cycle after release; no other events.
- key_in=4'b1101 for 25 cycles -> LONG code 1 at press+10; with KEY_REPEAT_EN REPEAT at +14, +18, +22 (three pulses), without none; no event on release.
- key_in=4'b0101 together, release bit 1 after 3 cycles keeping bit 3 low for 20 cycles -> SHORT code 1 only; key_busy stays high until 4'b1111; no event for key 3.
- Release tracked key exactly on terminal edge (low 10 samples) -> SHORT only, no LONG.
- Assert rst_n low at press+6 with key held, release rst_n -> no event during/at reset; new tracking starts, LONG 10 cycles after reset release.

Source files
------------

// File: rtl/key_event_gen.sv
// Turns debounced active-low key levels into single-cycle SHORT/LONG/REPEAT events for one tracked key.
// Optional feature: define KEY_REPEAT_EN to emit periodic REPEAT events while a key is held past LONG.
module key_event_gen #(
    parameter int NUM_KEYS    = 4,
    parameter int LONG_TIME   = 50_000_000,
    parameter int REPEAT_TIME = 10_000_000,
    parameter int CODE_W      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic                event_valid,
    output logic [1:0]          event_type,
    output logic [CODE_W-1:0]   event_code,
    output logic                key_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_LONG,
        S_WAIT_REL
    } state_t;

    localparam logic [1:0]  EV_SHORT    = 2'b01;
    localparam logic [1:0]  EV_LONG     = 2'b10;
    localparam logic [31:0] LONG_LAST   = 32'(LONG_TIME - 1);
    localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_TIME - 1);

    state_t              state;
    logic [31:0]         cnt;
    logic [CODE_W-1:0]   first_idx;
    logic                any_pressed;
    logic                all_released;
    logic                tracked_up;

    // Lowest-index pressed key wins when several go down together.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (!key_in[i]) begin
                first_idx = CODE_W'(i);
            end
        end
    end

    assign any_pressed  = ~&key_in;
    assign all_released = &key_in;
    // event_code doubles as the tracked-key register.
    assign tracked_up   = key_in[event_code];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            event_valid <= 1'b0;
            event_type  <= 2'b00;
            event_code  <= '0;
            key_busy    <= 1'b0;
        end else begin
            event_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_pressed) begin
                        event_code <= first_idx;
                        cnt        <= '0;
                        state      <= S_HELD;
                        key_busy   <= 1'b1;
                    end
                end
                S_HELD: begin
                    // Release is checked first so a release on the terminal edge stays SHORT.
                    if (tracked_up) begin
                        event_valid <= 1'b1;
                        event_type  <= EV_SHORT;
                        state       <= S_WAIT_REL;
                    end else if (cnt == LONG_LAST) begin
                        event_valid <= 1'b1;
                        event_type  <= EV_LONG;
                        cnt         <= '0;
                        state       <= S_LONG;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_LONG: begin
                    if (tracked_up) begin
                        state <= S_WAIT_REL;
                    end else if (cnt == REPEAT_LAST) begin
                        cnt <= '0;
`ifdef KEY_REPEAT_EN
                        event_valid <= 1'b1;
                        event_type  <= 2'b11;
`endif
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_WAIT_REL: begin
                    if (all_released) begin
                        state    <= S_IDLE;
                        key_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    key_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_gen.sv
// Bench for key_event_gen: directed and random key timelines checked against a press/hold-duration model.
module tb_key_event_gen;

    localparam int NK   = 4;
    localparam int LT   = 10;
    localparam int RT   = 4;
    localparam int CW   = 2;
    localparam int MAXN = 512;
`ifdef KEY_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_in = '1;
    logic          event_valid;
    logic [1:0]    event_type;
    logic [CW-1:0] event_code;
    logic          key_busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [NK-1:0] stim[$];
    bit            exp_v[MAXN];
    logic [1:0]    exp_ty[MAXN];
    logic [CW-1:0] exp_cd[MAXN];
    bit            exp_busy[MAXN];

    always #5 clk = ~clk;

    key_event_gen #(
        .NUM_KEYS(NK),
        .LONG_TIME(LT),
        .REPEAT_TIME(RT),
        .CODE_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_in(key_in),
        .event_valid(event_valid),
        .event_type(event_type),
        .event_code(event_code),
        .key_busy(key_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic add(input logic [NK-1:0] v, input int len);
        for (int i = 0; i < len; i++) stim.push_back(v);
    endtask

    // Expected outputs after each edge t, derived from press times and hold durations.
    function automatic void build_expect();
        int n;
        int p;
        int k;
        int r;
        int w;
        int ty;
        int cd;
        int ev_ty[MAXN];
        int cd_set[MAXN];
        n = stim.size();
        for (int t = 0; t < MAXN; t++) begin
            ev_ty[t]    = 0;
            cd_set[t]   = -1;
            exp_busy[t] = 1'b0;
        end
        p = 0;
        while (p < n) begin
            if (stim[p] == '1) begin
                p++;
                continue;
            end
            k = 0;
            for (int i = NK - 1; i >= 0; i--) if (!stim[p][i]) k = i;
            cd_set[p] = k;
            r = p + 1;
            while (r < n && !stim[r][k]) r++;
            if (r - p <= LT) begin
                if (r < n) ev_ty[r] = 1;
            end else begin
                ev_ty[p + LT] = 2;
                if (REP_ON)
                    for (int e = p + LT + RT; e < r && e < n; e += RT) ev_ty[e] = 3;
            end
            w = r + 1;
            while (w < n && stim[w] != '1) w++;
            for (int t = p; t < w && t < n; t++) exp_busy[t] = 1'b1;
            p = w + 1;
        end
        ty = 0;
        cd = 0;
        for (int t = 0; t < n; t++) begin
            if (cd_set[t] >= 0) cd = cd_set[t];
            if (ev_ty[t] != 0) ty = ev_ty[t];
            exp_v[t]  = (ev_ty[t] != 0);
            exp_ty[t] = 2'(ty);
            exp_cd[t] = CW'(cd);
        end
    endfunction

    // Called at a falling edge; resets the DUT, then plays stim[] one sample per edge.
    task automatic run_scen(input string name);
        build_expect();
        rst_n  = 1'b0;
        key_in = stim[0];
        cyc    = -1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_valid", 32'(event_valid), 32'd0);
            check_val("rst_type", 32'(event_type), 32'd0);
            check_val("rst_code", 32'(event_code), 32'd0);
            check_val("rst_busy", 32'(key_busy), 32'd0);
        end
        rst_n = 1'b1;
        for (int t = 0; t < stim.size(); t++) begin
            key_in = stim[t];
            cyc    = t;
            @(posedge clk);
            #1;
            check_val({name, "_valid"}, 32'(event_valid), 32'(exp_v[t]));
            check_val({name, "_busy"}, 32'(key_busy), 32'(exp_busy[t]));
            check_val({name, "_type"}, 32'(event_type), 32'(exp_ty[t]));
            check_val({name, "_code"}, 32'(event_code), 32'(exp_cd[t]));
            if (event_valid)
                $display("%s t=%0d event type=%b code=%0d", name, t, event_type, event_code);
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);

        stim.delete(); add(4'b1111, 5);
        run_scen("idle");

        stim.delete(); add(4'b1011, 5); add(4'b1111, 5);
        run_scen("short");

        stim.delete(); add(4'b1101, 25); add(4'b1111, 5);
        run_scen("long");

        stim.delete(); add(4'b0101, 3); add(4'b0111, 20); add(4'b1111, 4);
        run_scen("multi");

        stim.delete(); add(4'b1111, 2); add(4'b1110, 10); add(4'b1111, 4);
        run_scen("edge_short");

        stim.delete(); add(4'b1111, 2); add(4'b1110, 11); add(4'b1111, 4);
        run_scen("edge_long");

        stim.delete(); add(4'b1111, 2); add(4'b1101, 7);
        run_scen("pre_rst");

        stim.delete(); add(4'b1101, 15); add(4'b1111, 3);
        run_scen("post_rst");

        for (int s = 0; s < 16; s++) begin
            stim.delete();
            while (stim.size() < 200) begin
                if ($urandom_range(0, 2) == 0) add(4'b1111, int'($urandom_range(1, 6)));
                else add(4'($urandom), int'($urandom_range(1, 30)));
            end
            run_scen("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
